// File: rtl/reg_dst_pipe_pkg.sv
// Shared encodings and default widths for the write-destination pipeline.
package cpu_defs;

   localparam int AW_DEF       = 5;
   localparam int TW_DEF       = 2;
   localparam int LINK_REG_DEF = 31;

   typedef enum logic [1:0] {
      REG_DST_RT   = 2'b00,
      REG_DST_RD   = 2'b01,
      REG_DST_LINK = 2'b10,
      REG_DST_COND = 2'b11
   } reg_dst_e;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_E  = 2'b01,
      FWD_M  = 2'b10,
      FWD_W  = 2'b11
   } fwd_e;

endpackage

// File: rtl/reg_dst_pipe_if.sv
// D-stage instruction fields in, tracked destinations and hazard/forward controls out.
interface reg_dst_pipe_if import cpu_defs::*; #(
   parameter int AW = AW_DEF,
   parameter int TW = TW_DEF
) ();

   logic [AW-1:0] rs_d;
   logic [AW-1:0] rt_d;
   logic [AW-1:0] rd_d;
   logic [1:0]    reg_dst_d;
   logic          cond_d;
   logic [TW-1:0] tnew_d;
   logic [TW-1:0] tuse_rs_d;
   logic [TW-1:0] tuse_rt_d;

   logic          stall_req;
   logic [1:0]    fwd_rs_d;
   logic [1:0]    fwd_rt_d;
   logic [AW-1:0] a3_e;
   logic [AW-1:0] a3_m;
   logic [AW-1:0] a3_w;
   logic [TW-1:0] tnew_e;
   logic [TW-1:0] tnew_m;

   modport master (
      output rs_d, rt_d, rd_d, reg_dst_d, cond_d, tnew_d, tuse_rs_d, tuse_rt_d,
      input  stall_req, fwd_rs_d, fwd_rt_d, a3_e, a3_m, a3_w, tnew_e, tnew_m
   );

   modport slave (
      input  rs_d, rt_d, rd_d, reg_dst_d, cond_d, tnew_d, tuse_rs_d, tuse_rt_d,
      output stall_req, fwd_rs_d, fwd_rt_d, a3_e, a3_m, a3_w, tnew_e, tnew_m
   );

endinterface

// File: rtl/reg_dst_pipe_hazard_src_check.sv
// Stall and forward-select decision for one D-stage source register.
module hazard_src_check import cpu_defs::*; #(
   parameter int AW = AW_DEF,
   parameter int TW = TW_DEF
) (
   input  logic [AW-1:0] src,
   input  logic [TW-1:0] tuse,
   input  logic [AW-1:0] a3_e,
   input  logic [TW-1:0] tnew_e,
   input  logic [AW-1:0] a3_m,
   input  logic [TW-1:0] tnew_m,
   input  logic [AW-1:0] a3_w,
   output logic          stall,
   output logic [1:0]    fwd
);

   logic hit_e, hit_m, hit_w;

   // $0 never matches, so bubbles and non-writing instructions are invisible
   assign hit_e = (src != '0) && (a3_e == src);
   assign hit_m = (src != '0) && (a3_m == src);
   assign hit_w = (src != '0) && (a3_w == src);

   assign stall = (hit_e && (tnew_e > tuse)) || (hit_m && (tnew_m > tuse));

   // youngest match wins; a not-yet-ready young match hides older copies
   always_comb begin
      fwd = FWD_RF;
      if (hit_e)
         fwd = (tnew_e == '0) ? FWD_E : FWD_RF;
      else if (hit_m)
         fwd = (tnew_m == '0) ? FWD_M : FWD_RF;
      else if (hit_w)
         fwd = FWD_W;
   end

endmodule

// File: rtl/reg_dst_pipe.sv
// Decodes the write destination in D and tracks it with its Tnew through E/M/W,
// producing the D-stage stall request and rs/rt forwarding selects.
module reg_dst_pipe import cpu_defs::*; #(
   parameter int AW       = AW_DEF,
   parameter int LINK_REG = LINK_REG_DEF,
   parameter int TW       = TW_DEF
) (
   input logic           clk,
   input logic           reset,
   reg_dst_pipe_if.slave bus
);

   logic [AW-1:0]         a3_dec;
   logic [AW-1:0]         a3_e_q, a3_m_q, a3_w_q;
   logic [TW-1:0]         tnew_e_q, tnew_m_q;
   logic                  stall;
   logic [1:0][AW-1:0]    src;
   logic [1:0][TW-1:0]    tuse;
   logic [1:0]            stall_src;
   logic [1:0][1:0]       fwd_src;

   // destination select; conditional link with a false condition writes nothing
   always_comb begin
      a3_dec = '0;
      case (reg_dst_e'(bus.reg_dst_d))
         REG_DST_RT:   a3_dec = bus.rt_d;
         REG_DST_RD:   a3_dec = bus.rd_d;
         REG_DST_LINK: a3_dec = AW'(LINK_REG);
         REG_DST_COND: a3_dec = bus.cond_d ? AW'(LINK_REG) : '0;
         default:      a3_dec = '0;
      endcase
   end

   assign src[0]  = bus.rs_d;
   assign src[1]  = bus.rt_d;
   assign tuse[0] = bus.tuse_rs_d;
   assign tuse[1] = bus.tuse_rt_d;

   for (genvar s = 0; s < 2; s++) begin : g_src
      hazard_src_check #(.AW(AW), .TW(TW)) u_chk (
         .src    (src[s]),
         .tuse   (tuse[s]),
         .a3_e   (a3_e_q),
         .tnew_e (tnew_e_q),
         .a3_m   (a3_m_q),
         .tnew_m (tnew_m_q),
         .a3_w   (a3_w_q),
         .stall  (stall_src[s]),
         .fwd    (fwd_src[s])
      );
   end

   assign stall = |stall_src;

   // advance E/M/W every cycle; a stall drops a bubble into E while D is held
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a3_e_q   <= '0;
         tnew_e_q <= '0;
         a3_m_q   <= '0;
         tnew_m_q <= '0;
         a3_w_q   <= '0;
      end else begin
         a3_e_q   <= stall ? '0 : a3_dec;
         tnew_e_q <= stall ? '0 : bus.tnew_d;
         a3_m_q   <= a3_e_q;
         tnew_m_q <= (tnew_e_q == '0) ? '0 : tnew_e_q - TW'(1);
         a3_w_q   <= a3_m_q;
      end
   end

   assign bus.stall_req = stall;
   assign bus.fwd_rs_d  = fwd_src[0];
   assign bus.fwd_rt_d  = fwd_src[1];
   assign bus.a3_e      = a3_e_q;
   assign bus.a3_m      = a3_m_q;
   assign bus.a3_w      = a3_w_q;
   assign bus.tnew_e    = tnew_e_q;
   assign bus.tnew_m    = tnew_m_q;

endmodule
